// File: rtl/usr_shift_seq.sv
// rtl/usr_shift_seq.sv - command sequencer driving an external universal shift register
// Accepts load/shift/rotate commands and steps the register through LOAD, SHIFT and DONE.
module usr_shift_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic             abort,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_s,
    output logic [WIDTH-1:0] usr_pin,
    output logic             usr_srin,
    output logic             usr_slin,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_lat_q, cnt_lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             aborted_q, aborted_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            data_q    <= '0;
            cnt_lat_q <= '0;
            cnt_q     <= '0;
            fill_q    <= 1'b0;
            aborted_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            cnt_lat_q <= cnt_lat_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            aborted_q <= aborted_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        cnt_lat_d = cnt_lat_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        aborted_d = 1'b0;
        result_d  = result_q;
        usr_s     = 2'b00;
        usr_srin  = 1'b0;
        usr_slin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    data_d    = cmd_data;
                    cnt_lat_d = cmd_cnt;
                    fill_d    = cmd_fill;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                usr_s = 2'b11;
                cnt_d = cnt_lat_q;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (op_q != OP_LOAD && cnt_lat_q != '0) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SHR: begin
                        usr_s    = 2'b01;
                        usr_srin = fill_q;
                    end
                    OP_SHL: begin
                        usr_s    = 2'b10;
                        usr_slin = fill_q;
                    end
                    // Rotate feeds the outgoing LSB straight back into the MSB.
                    OP_ROR: begin
                        usr_s    = 2'b01;
                        usr_srin = usr_q[0];
                    end
                    default: usr_s = 2'b00;
                endcase
                cnt_d = cnt_q - 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d = usr_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated by rst so the handshake is closed for as long as reset is held.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign usr_pin   = data_q;
    assign aborted   = aborted_q;
    assign result    = result_q;

endmodule

// File: tb/tb_usr_shift_seq.sv
// tb/tb_usr_shift_seq.sv - directed self-checking bench for usr_shift_seq
// An external universal shift register is modelled here and fed back on usr_q.
module tb_usr_shift_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic       cmd_fill;
    logic       abort;
    logic [3:0] usr_q;
    logic [1:0] usr_s;
    logic [3:0] usr_pin;
    logic       usr_srin;
    logic       usr_slin;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] result;

    int passed;
    int total;

    usr_shift_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .cmd_fill  (cmd_fill),
        .abort     (abort),
        .usr_q     (usr_q),
        .usr_s     (usr_s),
        .usr_pin   (usr_pin),
        .usr_srin  (usr_srin),
        .usr_slin  (usr_slin),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            usr_q <= 4'b0000;
        end else begin
            case (usr_s)
                2'b01:   usr_q <= {usr_srin, usr_q[3:1]};
                2'b10:   usr_q <= {usr_q[2:0], usr_slin};
                2'b11:   usr_q <= usr_pin;
                default: usr_q <= usr_q;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                           input logic fill, input logic abort_acc, input logic abort_done,
                           input logic [3:0] exp_res);
        int       cyc;
        int       shifts;
        int       exp_shifts;
        logic     seen_done;
        logic [1:0] exp_s;
        logic     exp_srin;
        logic     exp_slin;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        abort     = abort_acc;
        chk("ready_before_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk("load_usr_s", usr_s, 2'b11);
        chk("load_usr_pin", usr_pin, data);
        chk("load_busy", busy, 1);
        chk("load_ready", cmd_ready, 0);
        exp_s      = (op == 2'b10) ? 2'b10 : 2'b01;
        exp_shifts = (op == 2'b00) ? 0 : int'(cnt);
        cyc        = 1;
        shifts     = 0;
        seen_done  = 1'b0;
        while (!seen_done && cyc < 20) begin
            tick();
            cyc = cyc + 1;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                shifts   = shifts + 1;
                exp_srin = (op == 2'b01) ? fill : (op == 2'b11) ? usr_q[0] : 1'b0;
                exp_slin = (op == 2'b10) ? fill : 1'b0;
                chk("shift_usr_s", usr_s, exp_s);
                chk("shift_srin", usr_srin, exp_srin);
                chk("shift_slin", usr_slin, exp_slin);
            end
        end
        chk("done_seen", seen_done, 1);
        chk("done_latency", cyc, exp_shifts + 2);
        chk("shift_cycles", shifts, exp_shifts);
        chk("done_usr_s", usr_s, 2'b00);
        chk("done_busy", busy, 1);
        abort = abort_done;
        tick();
        abort = 1'b0;
        chk("post_done_pulse", done, 0);
        chk("post_aborted", aborted, 0);
        chk("post_result", result, exp_res);
        chk("post_ready", cmd_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0000;
        cmd_cnt   = 3'd0;
        cmd_fill  = 1'b0;
        abort     = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_usr_s", usr_s, 2'b00);
        chk("rst_usr_pin", usr_pin, 4'b0000);
        chk("rst_srin", usr_srin, 0);
        chk("rst_slin", usr_slin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_result", result, 4'b0000);
        chk("rst_ready_held", cmd_ready, 0);
        tick();
        tick();
        chk("rst_ready_still_held", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", cmd_ready, 1);
        tick();

        // shift right with zero fill
        run_cmd(2'b01, 4'b1011, 3'd2, 1'b0, 1'b0, 1'b0, 4'b0010);
        // shift left with one fill, accepted together with an abort in IDLE
        run_cmd(2'b10, 4'b0001, 3'd3, 1'b1, 1'b1, 1'b0, 4'b1111);
        // rotate right once; abort during DONE must be ignored
        run_cmd(2'b11, 4'b1011, 3'd1, 1'b0, 1'b0, 1'b1, 4'b1101);
        chk("ror_srin_was_one", usr_q, 4'b1101);
        // load only never shifts, even with nonzero count
        run_cmd(2'b00, 4'b0110, 3'd5, 1'b1, 1'b0, 1'b0, 4'b0110);
        // zero count shift goes straight from LOAD to DONE
        run_cmd(2'b01, 4'b1001, 3'd0, 1'b1, 1'b0, 1'b0, 4'b1001);
        // full count rotate wraps: 7 rotations of 0011 = 1 rotation left = 0110
        run_cmd(2'b11, 4'b0011, 3'd7, 1'b0, 1'b0, 1'b0, 4'b0110);

        // abort in the 3rd SHIFT cycle
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'b1100;
        cmd_cnt   = 3'd7;
        cmd_fill  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_usr_s", usr_s, 2'b01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_no_done", done, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_usr_s", usr_s, 2'b00);
        chk("abort_busy", busy, 0);
        chk("abort_result_kept", result, 4'b0110);
        tick();
        chk("abort_pulse_one_cycle", aborted, 0);
        chk("abort_still_no_done", done, 0);

        // asynchronous reset in the middle of SHIFT
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 4'b1010;
        cmd_cnt   = 3'd6;
        cmd_fill  = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid_shift_usr_s", usr_s, 2'b10);
        rst = 1'b1;
        #1;
        chk("async_rst_usr_s", usr_s, 2'b00);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_usr_pin", usr_pin, 4'b0000);
        chk("async_rst_result", result, 4'b0000);
        chk("async_rst_ready", cmd_ready, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_aborted", aborted, 0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_ready_release", cmd_ready, 1);
        tick();
        chk("post_rst_no_done", done, 0);
        chk("post_rst_no_aborted", aborted, 0);

        run_cmd(2'b01, 4'b1011, 3'd2, 1'b0, 1'b0, 1'b0, 4'b0010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
